// File: rtl/gen_defs_pkg.sv
// Shared encodings for the waveform sequencer: waveform selects and FSM states.
// Used by the top and the sine ROM.
package gen_defs;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int SINE_IDX_BITS = 6;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM, 64 entries, magnitude scaled to MAG_BITS.
// Latency: one registered cycle; no backpressure (free-running lookup).
// Used only when the top is built with SINE_LUT_EN.
module sine_quarter_lut
  import gen_defs::*;
#(
  parameter int MAG_BITS = 7
) (
  input  logic                     CLK,
  input  logic [SINE_IDX_BITS-1:0] idx,
  output logic [MAG_BITS-1:0]      mag
);

  localparam int W = MAG_BITS + 8;

  // round(255 * sin(i * pi / 128)), i = 0..63
  localparam logic [7:0] ROM [0:63] = '{
    8'd0,   8'd6,   8'd13,  8'd19,  8'd25,  8'd31,  8'd37,  8'd44,
    8'd50,  8'd56,  8'd62,  8'd68,  8'd74,  8'd80,  8'd86,  8'd92,
    8'd98,  8'd103, 8'd109, 8'd115, 8'd120, 8'd126, 8'd131, 8'd136,
    8'd142, 8'd147, 8'd152, 8'd157, 8'd162, 8'd167, 8'd171, 8'd176,
    8'd180, 8'd185, 8'd189, 8'd193, 8'd197, 8'd201, 8'd205, 8'd208,
    8'd212, 8'd215, 8'd219, 8'd222, 8'd225, 8'd228, 8'd231, 8'd233,
    8'd236, 8'd238, 8'd240, 8'd242, 8'd244, 8'd246, 8'd247, 8'd249,
    8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255
  };

  // Table is a fraction of 256; rescale to the requested magnitude width.
  always_ff @(posedge CLK) begin
    mag <= MAG_BITS'((W'(ROM[idx]) << MAG_BITS) >> 8);
  end

endmodule

// File: rtl/wave_sequencer.sv
// Phase-accumulating waveform sequencer stepped by the divided-clock tick.
// Latency: phase at tick edge E, sample at E+1 (sine at E+2 when SINE_LUT_EN is defined).
// No backpressure: every accepted tick produces exactly one sample_valid pulse.
module wave_sequencer
  import gen_defs::*;
#(
  parameter int PHASE_BITS = 8,
  parameter int PHASE_STEP = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  tick_in,
  input  logic                  run,
  input  logic                  clear,
  input  logic [1:0]            wave_sel,
  output logic [PHASE_BITS-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  period_done,
  output logic [PHASE_BITS-1:0] phase_out,
  output logic                  busy
);

  localparam int N = PHASE_BITS;
  localparam logic [N-1:0] STEP = N'(PHASE_STEP);
  localparam logic [N-1:0] MID  = {1'b1, {(N-1){1'b0}}};

  state_e         state;
  wave_e          wave_q;
  logic           tick_q;
  logic           upd_q;
  logic [N-1:0]   phase;
  logic [N:0]     sum;
  logic           rise;

  assign rise      = tick_in & ~tick_q;
  assign sum       = {1'b0, phase} + {1'b0, STEP};
  assign busy      = (state != ST_IDLE);
  assign phase_out = phase;

  function automatic logic [N-1:0] wave_fn(input wave_e sel, input logic [N-1:0] p);
    logic [N-1:0] dbl;
    dbl = {p[N-2:0], 1'b0};
    case (sel)
      WAVE_SQUARE: wave_fn = {N{p[N-1]}};
      WAVE_SAW:    wave_fn = p;
      WAVE_TRI:    wave_fn = p[N-1] ? ~dbl : dbl;
      default:     wave_fn = MID;
    endcase
  endfunction

`ifdef SINE_LUT_EN
  logic [SINE_IDX_BITS-1:0] raw_idx;
  logic [SINE_IDX_BITS-1:0] lut_idx;
  logic [N-2:0]             lut_mag;
  logic                     sine_pend;
  logic                     sine_neg;

  // Narrow accumulators pad the missing low index bits with zeros.
  if (N >= 8) begin : g_idx_full
    assign raw_idx = phase[N-3:N-8];
  end else begin : g_idx_pad
    assign raw_idx = {phase[N-3:0], {(8-N){1'b0}}};
  end

  assign lut_idx = phase[N-2] ? ~raw_idx : raw_idx;

  sine_quarter_lut #(.MAG_BITS(N-1)) u_sine_lut (
    .CLK (CLK),
    .idx (lut_idx),
    .mag (lut_mag)
  );
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_q       <= 1'b0;
      phase        <= '0;
      wave_q       <= WAVE_SQUARE;
      state        <= ST_IDLE;
      upd_q        <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      period_done  <= 1'b0;
`ifdef SINE_LUT_EN
      sine_pend    <= 1'b0;
      sine_neg     <= 1'b0;
`endif
    end else begin
      tick_q       <= tick_in;
      sample_valid <= 1'b0;
      period_done  <= 1'b0;
      upd_q        <= 1'b0;
`ifdef SINE_LUT_EN
      sine_pend    <= 1'b0;
`endif
      if (clear) begin
        state      <= ST_IDLE;
        phase      <= '0;
        sample_out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            phase <= '0;
            if (run) begin
              state  <= ST_RUN;
              wave_q <= wave_e'(wave_sel);
            end
          end
          ST_RUN: begin
            if (!run) begin
              state <= ST_HOLD;
            end else if (rise) begin
              phase <= sum[N-1:0];
              upd_q <= 1'b1;
              // Select changes only land on a period boundary to keep the output glitch-free.
              if (sum[N]) begin
                period_done <= 1'b1;
                wave_q      <= wave_e'(wave_sel);
              end
            end
          end
          ST_HOLD: begin
            if (run) state <= ST_RUN;
          end
          default: state <= ST_IDLE;
        endcase

        if (upd_q) begin
`ifdef SINE_LUT_EN
          if (wave_q == WAVE_SINE) begin
            sine_pend <= 1'b1;
            sine_neg  <= phase[N-1];
          end else begin
            sample_out   <= wave_fn(wave_q, phase);
            sample_valid <= 1'b1;
          end
`else
          sample_out   <= wave_fn(wave_q, phase);
          sample_valid <= 1'b1;
`endif
        end

`ifdef SINE_LUT_EN
        if (sine_pend) begin
          sample_out   <= sine_neg ? (MID - {1'b0, lut_mag}) : (MID + {1'b0, lut_mag});
          sample_valid <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer (PHASE_BITS=8, PHASE_STEP=16).
module tb_wave_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, tick_in, run, clear;
  logic [1:0] wave_sel;
  logic [7:0] sample_out, phase_out;
  logic       sample_valid, period_done, busy;

  int tests = 0;
  int fails = 0;
  logic v0, v1, v2, pd0, pd1;
  int vcount, pdcount, timing_bad;
  bit expect_late;

  always #5 CLK = ~CLK;

  wave_sequencer #(.PHASE_BITS(8), .PHASE_STEP(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .tick_in      (tick_in),
    .run          (run),
    .clear        (clear),
    .wave_sel     (wave_sel),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .period_done  (period_done),
    .phase_out    (phase_out),
    .busy         (busy)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One tick pulse: observations after edge E, E+1 and E+2.
  task automatic tick();
    tick_in = 1'b1;
    cyc(); v0 = sample_valid; pd0 = period_done;
    tick_in = 1'b0;
    cyc(); v1 = sample_valid; pd1 = period_done;
    cyc(); v2 = sample_valid;
    vcount  += int'(v0) + int'(v1) + int'(v2);
    pdcount += int'(pd0) + int'(pd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (expect_late ? !(v0 == 1'b0 && v1 == 1'b0 && v2 == 1'b1)
                      : !(v0 == 1'b0 && v1 == 1'b1 && v2 == 1'b0))
        timing_bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; tick_in = 1'b0; run = 1'b0; clear = 1'b0; wave_sel = 2'd0;
    expect_late = 1'b0; vcount = 0; pdcount = 0; timing_bad = 0;
    cyc(); cyc();
    check("reset_phase",  phase_out,    8'h00);
    check("reset_sample", sample_out,   8'h00);
    check("reset_valid",  sample_valid, 1'b0);
    check("reset_pd",     period_done,  1'b0);
    check("reset_busy",   busy,         1'b0);

    // Sawtooth, three ticks
    RESET = 1'b0; wave_sel = 2'd1; run = 1'b1;
    cyc();
    check("start_busy",  busy,      1'b1);
    check("start_phase", phase_out, 8'h00);
    ticks(3);
    check("saw3_phase",  phase_out,  8'h30);
    check("saw3_sample", sample_out, 8'h30);
    check("saw3_vcount", vcount,     3);
    check("saw3_timing", timing_bad, 0);

    // Clear mid-RUN at 0x70
    ticks(4);
    check("pre_clear_phase", phase_out, 8'h70);
    clear = 1'b1; wave_sel = 2'd2;
    cyc();
    check("clear_phase",  phase_out,    8'h00);
    check("clear_sample", sample_out,   8'h00);
    check("clear_busy",   busy,         1'b0);
    check("clear_valid",  sample_valid, 1'b0);
    check("clear_pd",     period_done,  1'b0);
    clear = 1'b0;
    cyc();

    // Triangle, select change mid-period, wrap
    pdcount = 0;
    ticks(4);
    check("tri_40", sample_out, 8'h80);
    ticks(8);
    check("tri_c0", sample_out, 8'h7F);
    wave_sel = 2'd1;
    ticks(3);
    check("tri_f0_phase", phase_out,  8'hF0);
    check("tri_f0",       sample_out, 8'h1F);
    tick();
    check("wrap_phase",   phase_out, 8'h00);
    check("wrap_pd_e",    pd0,       1'b1);
    check("wrap_pd_e1",   pd1,       1'b0);
    check("wrap_pdcount", pdcount,   1);
    ticks(1);
    check("post_wrap_saw", sample_out, 8'h10);

    // Sawtooth -> square change at 0x50
    ticks(4);
    check("saw_50_phase", phase_out, 8'h50);
    wave_sel = 2'd0;
    ticks(10);
    check("saw_f0", sample_out, 8'hF0);
    ticks(2);
    check("sq_10", sample_out, 8'h00);
    ticks(7);
    check("sq_80_phase", phase_out,  8'h80);
    check("sq_80",       sample_out, 8'hFF);

    // HOLD entered on the same edge as a rise
    tick_in = 1'b1; run = 1'b0;
    cyc();
    check("hold_phase", phase_out,    8'h80);
    check("hold_busy",  busy,         1'b1);
    check("hold_valid", sample_valid, 1'b0);
    tick_in = 1'b0;
    cyc();
    check("hold_valid2", sample_valid, 1'b0);
    wave_sel = 2'd1;
    tick();
    check("hold_tick_phase", phase_out,         8'h80);
    check("hold_tick_valid", {v0, v1, v2},      3'b000);
    check("hold_sample",     sample_out,        8'hFF);
    run = 1'b1;
    cyc();
    ticks(1);
    check("resume_phase",  phase_out,  8'h90);
    check("resume_sample", sample_out, 8'hFF);

    // RESET mid-RUN with tick_in held high through release
    tick_in = 1'b1; RESET = 1'b1;
    cyc();
    check("rst_phase",  phase_out,    8'h00);
    check("rst_sample", sample_out,   8'h00);
    check("rst_busy",   busy,         1'b0);
    check("rst_valid",  sample_valid, 1'b0);
    check("rst_pd",     period_done,  1'b0);
    RESET = 1'b0; wave_sel = 2'd2;
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vcount += int'(sample_valid) + int'(period_done);
    end
    check("rel_phase",  phase_out, 8'h00);
    check("rel_pulses", vcount,    0);
    check("rel_busy",   busy,      1'b1);
    tick_in = 1'b0;
    cyc();
    ticks(1);
    check("rel_tick_phase", phase_out,  8'h10);
    check("rel_tick_tri",   sample_out, 8'h20);

    // Select 3
    clear = 1'b1; wave_sel = 2'd3;
    cyc();
    clear = 1'b0;
    cyc();
`ifdef SINE_LUT_EN
    expect_late = 1'b1;
    ticks(4);
    check("sine_40", sample_out, 8'hFF);
    ticks(8);
    check("sine_c0", sample_out, 8'h01);
    ticks(4);
    check("sine_00_phase", phase_out,  8'h00);
    check("sine_00",       sample_out, 8'h80);
`else
    ticks(1);
    check("alt_phase", phase_out,  8'h10);
    check("alt_mid",   sample_out, 8'h80);
    ticks(4);
    check("alt_mid2",  sample_out, 8'h80);
`endif
    check("timing_all", timing_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
